// File: rtl/dmem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl_if
// Word-granular request/response bus between the data-memory access
// controller (master) and the data-cache wrapper (slave).
//   req_cpu  : request strobe, accepted on a cycle with req_cpu && !stall
//   read     : read command
//   write    : write command
//   address  : word-aligned byte address
//   wrdata   : write data
//   stall    : cache cannot accept the request this cycle
//   done     : transaction complete, rddata valid in the same cycle
//   rddata   : read data
// ---------------------------------------------------------------------------
interface dmem_access_ctrl_if;
    logic        req_cpu;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] wrdata;
    logic        stall;
    logic        done;
    logic [31:0] rddata;

    modport master (
        output req_cpu, read, write, address, wrdata,
        input  stall, done, rddata
    );

    modport slave (
        input  req_cpu, read, write, address, wrdata,
        output stall, done, rddata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
// Converts RISC-V loads/stores (byte/half/word) into word-aligned 32-bit
// cache transactions. Sub-word stores are read-modify-write; loads return
// right-justified, sign/zero-extended data with a one-cycle ld_valid pulse.
// Misaligned requests are rejected with err_misalign and never issued; a
// transaction that sees no done for TIMEOUT_CYCLES is aborted with
// err_timeout.
// Ports:
//   clk, rstn          : clock, async active-low reset
//   op_*               : upstream request (valid/ready handshake)
//   ld_valid, ld_data  : load result
//   err_misalign       : pulse on rejected misaligned request
//   err_timeout        : pulse on aborted transaction
//   busy               : controller not idle
//   cache              : cache bus (master side)
//   cnt_load/store/rmw : saturating completion counters
// ---------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic                    op_load,
    input  logic                    op_store,
    input  logic [31:0]             op_addr,
    input  logic [31:0]             op_wdata,
    input  logic [1:0]              op_store_sel,
    input  logic [2:0]              op_load_sel,
    output logic                    ld_valid,
    output logic [31:0]             ld_data,
    output logic                    err_misalign,
    output logic                    err_timeout,
    output logic                    busy,
    dmem_access_ctrl_if.master      cache,
    output logic [CNT_W-1:0]        cnt_load,
    output logic [CNT_W-1:0]        cnt_store,
    output logic [CNT_W-1:0]        cnt_rmw
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_WAIT = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // Little-endian extraction of the addressed lane, optionally sign-extended.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input size_e       size,
                                                 input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed byte/half of the memory word with store data.
    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input size_e       size,
                                                input logic [31:0] wd);
        logic [31:0] r;
        r = word;
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'b00:   r[7:0]   = wd[7:0];
                    2'b01:   r[15:8]  = wd[7:0];
                    2'b10:   r[23:16] = wd[7:0];
                    default: r[31:24] = wd[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off[1]) r[31:16] = wd[15:0];
                else        r[15:0]  = wd[15:0];
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    state_e            state_r, state_n;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic              op_ready_r, busy_r, ld_valid_r, err_misalign_r, err_timeout_r;
    logic              req_cpu_r, read_r, write_r;
    logic [31:0]       ld_data_r, address_r, wrdata_r, wdata_r;
    logic [1:0]        off_r;
    size_e             size_r;
    logic              signed_r, rmw_r;
    logic [CNT_W-1:0]  cnt_load_r, cnt_store_r, cnt_rmw_r;

    logic              req_load_s, req_store_s, req_signed_s, misalign_s;
    size_e             req_size_s;
    logic              accept_s, start_s, reject_s;
    logic              rd_done_s, wr_done_s, tmo_hit_s;

    // Decode the incoming request: access size, extension and alignment.
    always_comb begin
        req_store_s  = op_store;
        req_load_s   = op_load & ~op_store;
        req_size_s   = SZ_WORD;
        req_signed_s = 1'b0;
        if (req_store_s) begin
            case (op_store_sel)
                2'b00:   req_size_s = SZ_BYTE;
                2'b01:   req_size_s = SZ_HALF;
                default: req_size_s = SZ_WORD;
            endcase
        end else begin
            case (op_load_sel)
                3'b000:  begin req_size_s = SZ_BYTE; req_signed_s = 1'b1; end
                3'b001:  begin req_size_s = SZ_HALF; req_signed_s = 1'b1; end
                3'b011:  req_size_s = SZ_BYTE;
                3'b100:  req_size_s = SZ_HALF;
                default: req_size_s = SZ_WORD;
            endcase
        end
        case (req_size_s)
            SZ_HALF: misalign_s = op_addr[0];
            SZ_WORD: misalign_s = (op_addr[1:0] != 2'b00);
            default: misalign_s = 1'b0;
        endcase
        accept_s = op_valid & op_ready_r;
        start_s  = accept_s & (req_load_s | req_store_s) & ~misalign_s;
        reject_s = accept_s & (req_load_s | req_store_s) & misalign_s;
    end

    // Next-state logic; done is only honoured in the wait states.
    always_comb begin
        state_n   = state_r;
        rd_done_s = 1'b0;
        wr_done_s = 1'b0;
        tmo_hit_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start_s) begin
                    if (req_store_s && (req_size_s == SZ_WORD)) state_n = S_WR_REQ;
                    else                                          state_n = S_RD_REQ;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_RD_REQ: begin
                if (!cache.stall) state_n = S_RD_WAIT;
                else              state_n = S_RD_REQ;
            end
            S_RD_WAIT: begin
                if (cache.done) begin
                    rd_done_s = 1'b1;
                    state_n   = rmw_r ? S_WR_REQ : S_IDLE;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    tmo_hit_s = 1'b1;
                    state_n   = S_IDLE;
                end else begin
                    state_n = S_RD_WAIT;
                end
            end
            S_WR_REQ: begin
                if (!cache.stall) state_n = S_WR_WAIT;
                else              state_n = S_WR_REQ;
            end
            S_WR_WAIT: begin
                if (cache.done) begin
                    wr_done_s = 1'b1;
                    state_n   = S_IDLE;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    tmo_hit_s = 1'b1;
                    state_n   = S_IDLE;
                end else begin
                    state_n = S_WR_WAIT;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State register and wait-state timeout counter (cleared on any state change).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= S_IDLE;
            tmo_cnt_r <= '0;
        end else begin
            state_r <= state_n;
            if ((state_n != state_r) ||
                ((state_r != S_RD_WAIT) && (state_r != S_WR_WAIT))) begin
                tmo_cnt_r <= '0;
            end else begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end
        end
    end

    // Registered status and cache strobes, decoded from the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_ready_r     <= 1'b0;
            busy_r         <= 1'b0;
            req_cpu_r      <= 1'b0;
            read_r         <= 1'b0;
            write_r        <= 1'b0;
            ld_valid_r     <= 1'b0;
            ld_data_r      <= 32'h0000_0000;
            err_misalign_r <= 1'b0;
            err_timeout_r  <= 1'b0;
        end else begin
            op_ready_r     <= (state_n == S_IDLE);
            busy_r         <= (state_n != S_IDLE);
            req_cpu_r      <= (state_n == S_RD_REQ) || (state_n == S_WR_REQ);
            read_r         <= (state_n == S_RD_REQ);
            write_r        <= (state_n == S_WR_REQ);
            ld_valid_r     <= rd_done_s & ~rmw_r;
            err_misalign_r <= reject_s;
            err_timeout_r  <= tmo_hit_s;
            if (rd_done_s && !rmw_r) begin
                ld_data_r <= extract_load(cache.rddata, off_r, size_r, signed_r);
            end
        end
    end

    // Request capture and write-data formation (direct for SW, merged for RMW).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            address_r <= 32'h0000_0000;
            wrdata_r  <= 32'h0000_0000;
            wdata_r   <= 32'h0000_0000;
            off_r     <= 2'b00;
            size_r    <= SZ_WORD;
            signed_r  <= 1'b0;
            rmw_r     <= 1'b0;
        end else if (start_s) begin
            address_r <= {op_addr[31:2], 2'b00};
            wdata_r   <= op_wdata;
            off_r     <= op_addr[1:0];
            size_r    <= req_size_s;
            signed_r  <= req_signed_s;
            rmw_r     <= req_store_s && (req_size_s != SZ_WORD);
            if (req_store_s && (req_size_s == SZ_WORD)) begin
                wrdata_r <= op_wdata;
            end
        end else if (rd_done_s && rmw_r) begin
            wrdata_r <= merge_store(cache.rddata, off_r, size_r, wdata_r);
        end
    end

    // Saturating completion counters; aborted transactions never count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_load_r  <= '0;
            cnt_store_r <= '0;
            cnt_rmw_r   <= '0;
        end else begin
            if (rd_done_s && !rmw_r && (cnt_load_r != {CNT_W{1'b1}})) begin
                cnt_load_r <= cnt_load_r + CNT_W'(1);
            end
            if (wr_done_s && (cnt_store_r != {CNT_W{1'b1}})) begin
                cnt_store_r <= cnt_store_r + CNT_W'(1);
            end
            if (wr_done_s && rmw_r && (cnt_rmw_r != {CNT_W{1'b1}})) begin
                cnt_rmw_r <= cnt_rmw_r + CNT_W'(1);
            end
        end
    end

    assign op_ready      = op_ready_r;
    assign busy          = busy_r;
    assign ld_valid      = ld_valid_r;
    assign ld_data       = ld_data_r;
    assign err_misalign  = err_misalign_r;
    assign err_timeout   = err_timeout_r;
    assign cache.req_cpu = req_cpu_r;
    assign cache.read    = read_r;
    assign cache.write   = write_r;
    assign cache.address = address_r;
    assign cache.wrdata  = wrdata_r;
    assign cnt_load      = cnt_load_r;
    assign cnt_store     = cnt_store_r;
    assign cnt_rmw       = cnt_rmw_r;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_ctrl
// Directed bench: a single-word cache model with programmable done latency,
// per-request stall and done withholding; all expected values hand-computed.
// ---------------------------------------------------------------------------
module tb_dmem_access_ctrl;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             op_valid = 1'b0, op_ready;
    logic             op_load = 1'b0, op_store = 1'b0;
    logic [31:0]      op_addr = 32'h0, op_wdata = 32'h0;
    logic [1:0]       op_store_sel = 2'b00;
    logic [2:0]       op_load_sel = 3'b000;
    logic             ld_valid, err_misalign, err_timeout, busy;
    logic [31:0]      ld_data;
    logic [CNT_W-1:0] cnt_load, cnt_store, cnt_rmw;

    dmem_access_ctrl_if cif();

    dmem_access_ctrl #(.TIMEOUT_CYCLES(1024), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_load(op_load), .op_store(op_store),
        .op_addr(op_addr), .op_wdata(op_wdata),
        .op_store_sel(op_store_sel), .op_load_sel(op_load_sel),
        .ld_valid(ld_valid), .ld_data(ld_data),
        .err_misalign(err_misalign), .err_timeout(err_timeout),
        .busy(busy), .cache(cif),
        .cnt_load(cnt_load), .cnt_store(cnt_store), .cnt_rmw(cnt_rmw)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;

    // Cache model state and monitors
    logic [31:0] mem = 32'h0, rd_addr = 32'h0, wr_addr = 32'h0, wr_data = 32'h0, ld_last = 32'h0;
    int  rd_cnt = 0, wr_cnt = 0, req_cycles = 0, ld_pulses = 0, mis_pulses = 0, to_pulses = 0;
    int  stab_err = 0, ready_err = 0;
    int  done_delay = 0, stall_cfg = 0, stall_left = 0, wait_left = 0;
    bit  withhold = 1'b0, in_op = 1'b0, txn_busy = 1'b0, txn_wr = 1'b0;
    bit  prev_req = 1'b0, prev_stall = 1'b0, prev_rd = 1'b0, prev_done = 1'b0, prev_done_wr = 1'b0;
    logic [31:0] prev_addr = 32'h0, prev_wdata = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else             n_pass++;
    endtask

    // Cache model: books the previous edge, monitors outputs, drives the next cycle.
    initial begin
        cif.stall = 1'b0; cif.done = 1'b0; cif.rddata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (!rstn) begin
                txn_busy = 1'b0; prev_req = 1'b0; prev_stall = 1'b0; prev_done = 1'b0;
                stall_left = 0; cif.stall = 1'b0; cif.done = 1'b0;
            end else begin
                if (prev_done) begin
                    txn_busy = 1'b0;
                    if (prev_done_wr) in_op = 1'b0;
                end
                if (prev_req && !prev_stall) begin
                    if (prev_rd) begin
                        rd_cnt++; rd_addr = prev_addr;
                    end else begin
                        wr_cnt++; wr_addr = prev_addr; wr_data = prev_wdata; mem = prev_wdata;
                    end
                    txn_busy = 1'b1; txn_wr = !prev_rd; wait_left = done_delay;
                end
                if (cif.req_cpu) req_cycles++;
                if (ld_valid) begin ld_pulses++; ld_last = ld_data; end
                if (err_misalign) mis_pulses++;
                if (err_timeout) begin to_pulses++; txn_busy = 1'b0; end
                if (prev_req && prev_stall &&
                    (!cif.req_cpu || cif.address != prev_addr || cif.read != prev_rd ||
                     cif.write == prev_rd || (!prev_rd && cif.wrdata != prev_wdata)))
                    stab_err++;
                if (in_op && op_ready) ready_err++;
                if (cif.req_cpu && !prev_req) stall_left = stall_cfg;
                cif.stall = cif.req_cpu && (stall_left > 0);
                if (cif.stall) stall_left--;
                cif.done = 1'b0;
                if (txn_busy && !withhold) begin
                    if (wait_left == 0) begin cif.done = 1'b1; cif.rddata = mem; end
                    else wait_left--;
                end
                prev_req = cif.req_cpu; prev_stall = cif.stall; prev_rd = cif.read;
                prev_addr = cif.address; prev_wdata = cif.wrdata;
                prev_done = cif.done; prev_done_wr = txn_wr;
            end
        end
    end

    task automatic issue(input logic ld, input logic st, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] ss, input logic [2:0] ls);
        int n = 0;
        while (!op_ready && n < 200) begin @(posedge clk); #1; n++; end
        op_valid = 1'b1; op_load = ld; op_store = st; op_addr = a;
        op_wdata = wd; op_store_sel = ss; op_load_sel = ls;
        @(posedge clk); #1;
        op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (busy && n < limit) begin @(posedge clk); #1; n++; end
        @(posedge clk); #2;
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    int r0, w0, q0, m0, t0, l0;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, op_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pulses", {29'd0, ld_valid, err_misalign, err_timeout}, 32'd0);
        check("rst_cache", {29'd0, cif.req_cpu, cif.read, cif.write}, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", {31'd0, op_ready}, 32'd1);

        // LW with 3-cycle done latency
        mem = 32'h8899AABB; done_delay = 2;
        issue(1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 3'b010);
        wait_idle("lw", 50);
        check("lw_reads", rd_cnt, 32'd1);
        check("lw_addr", rd_addr, 32'h100);
        check("lw_pulses", ld_pulses, 32'd1);
        check("lw_data", ld_last, 32'h8899AABB);
        check("lw_cnt", 32'(cnt_load), 32'd1);

        // Sub-word loads on the same word
        done_delay = 0;
        issue(1'b1, 1'b0, 32'h103, 32'h0, 2'b00, 3'b000); wait_idle("lb", 50);
        check("lb_data", ld_last, 32'hFFFFFF88);
        issue(1'b1, 1'b0, 32'h103, 32'h0, 2'b00, 3'b011); wait_idle("lbu", 50);
        check("lbu_data", ld_last, 32'h00000088);
        issue(1'b1, 1'b0, 32'h102, 32'h0, 2'b00, 3'b001); wait_idle("lh", 50);
        check("lh_data", ld_last, 32'hFFFF8899);
        issue(1'b1, 1'b0, 32'h100, 32'h0, 2'b00, 3'b100); wait_idle("lhu", 50);
        check("lhu_data", ld_last, 32'h0000AABB);
        check("ld_cnt5", 32'(cnt_load), 32'd5);
        check("ld_pulses5", ld_pulses, 32'd5);

        // Read-modify-write stores and a plain word store
        mem = 32'h11223344; done_delay = 1; r0 = rd_cnt;
        issue(1'b0, 1'b1, 32'h101, 32'hFFFFFF5A, 2'b00, 3'b000); wait_idle("sb", 50);
        check("sb_read", rd_cnt - r0, 32'd1);
        check("sb_rd_addr", rd_addr, 32'h100);
        check("sb_wr_addr", wr_addr, 32'h100);
        check("sb_wrdata", wr_data, 32'h11225A44);
        check("sb_cnt_rmw", 32'(cnt_rmw), 32'd1);
        check("sb_cnt_store", 32'(cnt_store), 32'd1);
        mem = 32'h11223344;
        issue(1'b0, 1'b1, 32'h102, 32'h1234BEEF, 2'b01, 3'b000); wait_idle("sh", 50);
        check("sh_wrdata", wr_data, 32'hBEEF3344);
        check("sh_cnt_rmw", 32'(cnt_rmw), 32'd2);
        r0 = rd_cnt;
        issue(1'b0, 1'b1, 32'h104, 32'hCAFEF00D, 2'b10, 3'b000); wait_idle("sw", 50);
        check("sw_no_read", rd_cnt - r0, 32'd0);
        check("sw_wrdata", wr_data, 32'hCAFEF00D);
        check("sw_wr_addr", wr_addr, 32'h104);
        check("sw_cnt", {cnt_store, cnt_rmw}, {16'd3, 16'd2});

        // RMW with 5 stall cycles on both requests
        mem = 32'h11223344; stall_cfg = 5; r0 = rd_cnt; w0 = wr_cnt; q0 = req_cycles;
        issue(1'b0, 1'b1, 32'h100, 32'h00000077, 2'b00, 3'b000);
        in_op = 1'b1;
        wait_idle("stall", 100);
        in_op = 1'b0; stall_cfg = 0;
        check("stall_reads", rd_cnt - r0, 32'd1);
        check("stall_writes", wr_cnt - w0, 32'd1);
        check("stall_req_cycles", req_cycles - q0, 32'd12);
        check("stall_stable", stab_err, 32'd0);
        check("stall_ready_low", ready_err, 32'd0);
        check("stall_wrdata", wr_data, 32'h11223377);
        check("stall_cnt", {cnt_store, cnt_rmw}, {16'd4, 16'd3});

        // Misaligned requests
        q0 = req_cycles; m0 = mis_pulses;
        issue(1'b1, 1'b0, 32'h102, 32'h0, 2'b00, 3'b010); wait_idle("mis_lw", 10);
        issue(1'b0, 1'b1, 32'h101, 32'hABCD, 2'b01, 3'b000); wait_idle("mis_sh", 10);
        check("mis_pulses", mis_pulses - m0, 32'd2);
        check("mis_no_req", req_cycles - q0, 32'd0);
        check("mis_cnt", {cnt_load, cnt_store}, {16'd5, 16'd4});

        // Timeout on a load
        t0 = to_pulses; l0 = ld_pulses; withhold = 1'b1;
        issue(1'b1, 1'b0, 32'h100, 32'h0, 2'b00, 3'b010);
        wait_idle("tmo", 1100);
        withhold = 1'b0;
        check("tmo_pulse", to_pulses - t0, 32'd1);
        check("tmo_no_ld", ld_pulses - l0, 32'd0);
        check("tmo_cnt", 32'(cnt_load), 32'd5);
        check("tmo_ready", {31'd0, op_ready}, 32'd1);

        // Reset while in WR_WAIT
        withhold = 1'b1; w0 = wr_cnt;
        issue(1'b0, 1'b1, 32'h100, 32'h12345678, 2'b10, 3'b000);
        begin
            int n = 0;
            while (wr_cnt == w0 && n < 50) begin @(posedge clk); #2; n++; end
        end
        check("rst_wr_seen", wr_cnt - w0, 32'd1);
        @(posedge clk); #3;
        rstn = 1'b0; #1;
        check("midrst_cache", {29'd0, cif.req_cpu, cif.read, cif.write}, 32'd0);
        check("midrst_busy_ready", {30'd0, busy, op_ready}, 32'd0);
        check("midrst_addr", cif.address, 32'h0);
        check("midrst_wrdata", cif.wrdata, 32'h0);
        check("midrst_cnt", {cnt_store, cnt_load}, 32'h0);
        withhold = 1'b0;
        repeat (2) @(posedge clk);
        #4 rstn = 1'b1;
        l0 = ld_pulses;
        issue(1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 3'b010);
        wait_idle("post_rst", 50);
        check("post_rst_pulse", ld_pulses - l0, 32'd1);
        check("post_rst_data", ld_last, 32'h12345678);
        check("post_rst_cnt", 32'(cnt_load), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
